mem_ctrl: RTL and testbench

- Sequences and arbitrates the single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM).
- Splits each 1/2/4-byte request into byte cycles, assembles read data little-endian, and returns a one-cycle done pulse per requester.
- Sits between the pipeline stages and the external RAM/IO bus; requesters stall on req && !done.

---
 rtl/mem_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl: arbitrates and sequences the single byte-wide RAM port between
// instruction fetch (IF) and the load/store stage (MEM).
//
// Each 1/2/4-byte request is split into byte cycles. Read data is assembled
// little-endian. Each requester gets a one-cycle done pulse when its
// transaction finishes.
//
// Optional feature: define MEM_CTRL_RR_EN for a round-robin tie-break between
// IF and MEM. Without it, MEM always wins a simultaneous request.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global ready; 0 freezes the block (ram_wr forced 0)
//   if_req/if_addr    fetch request (always 4 bytes) and byte address
//   if_done/if_data   one-cycle completion pulse and fetched word
//   mem_req/mem_we    load/store request, 1 = store
//   mem_addr/mem_len  byte address and byte count (1, 2, anything else = 4)
//   mem_wdata         store data, low len bytes used
//   mem_done/mem_rdata one-cycle completion pulse, zero-extended load data
//   ram_din           RAM read byte, valid the cycle after its address
//   ram_dout/ram_a/ram_wr  RAM write byte, byte address, write strobe
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [2:0]        mem_len,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic                sel_mem_r;     // 1 = current transaction belongs to MEM
    logic [2:0]          n_r;           // effective byte count of the transaction
    logic [2:0]          cnt_r;         // cycles spent in RD/WR so far
    logic [DATA_W-1:0]   rbuf_r;        // read bytes captured so far
    logic [DATA_W-1:0]   wbuf_r;        // store bytes not yet driven, LSB first
    logic [ADDR_W-1:0]   ram_a_r;
    logic [7:0]          ram_dout_r;
    logic                ram_wr_r;
    logic                if_done_r;
    logic                mem_done_r;
    logic [DATA_W-1:0]   if_data_r;
    logic [DATA_W-1:0]   mem_rdata_r;

    logic                if_ok_s;
    logic                mem_ok_s;
    logic                grant_s;
    logic                grant_mem_s;
    logic                tie_mem_s;
    logic [2:0]          len_s;
    logic [1:0]          cap_idx_s;
    logic [DATA_W-1:0]   rd_word_s;

`ifdef MEM_CTRL_RR_EN
    logic                last_if_r;     // 1 = IF won the last grant, reset = MEM
`endif

    assign if_done   = if_done_r;
    assign if_data   = if_data_r;
    assign mem_done  = mem_done_r;
    assign mem_rdata = mem_rdata_r;
    assign ram_dout  = ram_dout_r;
    assign ram_a     = ram_a_r;
    // The RAM is frozen together with this block, so no strobe while rdy is low.
    assign ram_wr    = ram_wr_r & rdy;

    // Byte captured on this edge lands at lane cnt-1 (cnt runs 1..n while capturing).
    assign cap_idx_s = cnt_r[1:0] - 2'd1;

    // Read word with the byte currently on ram_din merged into its lane.
    always_comb begin
        rd_word_s = rbuf_r;
        rd_word_s[{cap_idx_s, 3'b000} +: 8] = ram_din;
    end

    // Arbitration, length decode and next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        // A requester whose done pulse is high is dropping its request this cycle.
        if_ok_s     = if_req && !if_done_r;
        mem_ok_s    = mem_req && !mem_done_r;
        grant_s     = if_ok_s || mem_ok_s;
`ifdef MEM_CTRL_RR_EN
        tie_mem_s   = last_if_r;
`else
        tie_mem_s   = 1'b1;
`endif
        if (if_ok_s && mem_ok_s) begin
            grant_mem_s = tie_mem_s;
        end else begin
            grant_mem_s = mem_ok_s;
        end
        case (mem_len)
            3'd1:    len_s = 3'd1;
            3'd2:    len_s = 3'd2;
            default: len_s = 3'd4;
        endcase
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    if (grant_mem_s && mem_we) begin
                        state_nxt_s = WR;
                    end else begin
                        state_nxt_s = RD;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD: begin
                if (cnt_r == n_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RD;
                end
            end
            WR: begin
                if (cnt_r + 3'd1 == n_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WR;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register; rdy low holds the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else if (rdy) begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: address/byte sequencing, read assembly and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_mem_r   <= 1'b0;
            n_r         <= 3'd0;
            cnt_r       <= 3'd0;
            rbuf_r      <= {DATA_W{1'b0}};
            wbuf_r      <= {DATA_W{1'b0}};
            ram_a_r     <= {ADDR_W{1'b0}};
            ram_dout_r  <= 8'd0;
            ram_wr_r    <= 1'b0;
            if_done_r   <= 1'b0;
            mem_done_r  <= 1'b0;
            if_data_r   <= {DATA_W{1'b0}};
            mem_rdata_r <= {DATA_W{1'b0}};
`ifdef MEM_CTRL_RR_EN
            last_if_r   <= 1'b0;
`endif
        end else if (rdy) begin
            if_done_r  <= 1'b0;
            mem_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        sel_mem_r <= grant_mem_s;
                        ram_a_r   <= grant_mem_s ? mem_addr : if_addr;
                        n_r       <= grant_mem_s ? len_s : 3'd4;
                        cnt_r     <= 3'd0;
                        rbuf_r    <= {DATA_W{1'b0}};
                        if (grant_mem_s && mem_we) begin
                            ram_dout_r <= mem_wdata[7:0];
                            wbuf_r     <= mem_wdata >> 4'd8;
                            ram_wr_r   <= 1'b1;
                        end
`ifdef MEM_CTRL_RR_EN
                        last_if_r <= !grant_mem_s;
`endif
                    end
                end
                RD: begin
                    cnt_r <= cnt_r + 3'd1;
                    // Addresses run one cycle ahead of the captured bytes.
                    if (cnt_r + 3'd1 < n_r) begin
                        ram_a_r <= ram_a_r + ADDR_W'(1);
                    end
                    if (cnt_r != 3'd0) begin
                        rbuf_r <= rd_word_s;
                    end
                    if (cnt_r == n_r) begin
                        cnt_r <= 3'd0;
                        if (sel_mem_r) begin
                            mem_rdata_r <= rd_word_s;
                            mem_done_r  <= 1'b1;
                        end else begin
                            if_data_r   <= rd_word_s;
                            if_done_r   <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (cnt_r + 3'd1 == n_r) begin
                        cnt_r      <= 3'd0;
                        ram_wr_r   <= 1'b0;
                        mem_done_r <= 1'b1;
                    end else begin
                        cnt_r      <= cnt_r + 3'd1;
                        ram_a_r    <= ram_a_r + ADDR_W'(1);
                        ram_dout_r <= wbuf_r[7:0];
                        wbuf_r     <= wbuf_r >> 4'd8;
                    end
                end
                default: begin
                    cnt_r    <= 3'd0;
                    ram_wr_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl: directed self-checking bench for mem_ctrl. A behavioural byte
// RAM (frozen by rdy like the real one) answers the DUT; expected read words
// are queued when a request is driven and popped when a done pulse appears.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [2:0]  mem_len;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din = 8'd0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    logic [7:0]  ram [0:65535];

    typedef struct {
        bit          is_mem;
        logic [31:0] data;
    } sb_item_t;
    sb_item_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_data   (if_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_len   (mem_len),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_a     (ram_a),
        .ram_wr    (ram_wr)
    );

    always #5 clk = ~clk;

    // Byte RAM: read data one cycle after the address, frozen when rdy is low.
    always @(posedge clk) begin
        if (rdy) begin
            ram_din <= ram[ram_a[15:0]];
            if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit is_mem, input logic [31:0] data);
        sb_item_t e;
        e.is_mem = is_mem;
        e.data   = data;
        sb.push_back(e);
    endtask

    task automatic pop_check(input bit port_is_mem, input string tag);
        sb_item_t e;
        vectors++;
        assert (sb.size() > 0) else begin
            miscompares++;
            $error("FAIL %s: observed=unexpected done expected=queued result", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " port"}, {31'd0, port_is_mem}, {31'd0, e.is_mem});
            chk({tag, " data"}, port_is_mem ? mem_rdata : if_data, e.data);
        end
    endtask

    // Called at the negedge of cycle 0: drives a read, checks addresses,
    // done latency, data and that the done pulse is a single cycle.
    task automatic run_read(input bit is_mem, input logic [31:0] addr, input logic [2:0] len,
                            input int n, input logic [31:0] exp_data, input int exp_cyc,
                            input string tag);
        int cyc;
        bit seen;
        if (is_mem) begin
            mem_req = 1'b1; mem_we = 1'b0; mem_addr = addr; mem_len = len;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        push_exp(is_mem, exp_data);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc <= n) chk({tag, " ram_a"}, ram_a, addr + cyc - 1);
            if (is_mem ? mem_done : if_done) seen = 1'b1;
        end
        chk({tag, " done cycle"}, cyc, exp_cyc);
        if (seen) pop_check(is_mem, tag);
        if_req  = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
        chk({tag, " single pulse"}, {31'd0, is_mem ? mem_done : if_done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int if_n;
        int mem_n;
        int if_cyc;
        int mem_cyc;
        logic [31:0] w;

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h37;
        ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
        ram[16'h1004] = 8'h11; ram[16'h1005] = 8'h22;
        ram[16'h1006] = 8'h33; ram[16'h1007] = 8'h44;
        ram[16'h2003] = 8'hFF;
        ram[16'hFFFF] = 8'hAB; ram[16'h0000] = 8'hCD;
        ram[16'h3012] = 8'h5A;

        rst = 1'b1; rdy = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_len = 3'd0; mem_wdata = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst if_done",   {31'd0, if_done},  32'd0);
        chk("rst mem_done",  {31'd0, mem_done}, 32'd0);
        chk("rst if_data",   if_data,   32'd0);
        chk("rst mem_rdata", mem_rdata, 32'd0);
        chk("rst ram_a",     ram_a,     32'd0);
        chk("rst ram_dout",  {24'd0, ram_dout}, 32'd0);
        chk("rst ram_wr",    {31'd0, ram_wr},   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // IF word fetch and MEM loads, including address wrap and len=3 -> 4
        run_read(1'b0, 32'h0000_1000, 3'd4, 4, 32'h0000_3713, 6, "if fetch");
        run_read(1'b1, 32'h0000_2003, 3'd1, 1, 32'h0000_00FF, 3, "byte load");

        // Simultaneous requests
        if_req = 1'b1;  if_addr = 32'h0000_1000;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_1001; mem_len = 3'd1;
`ifdef MEM_CTRL_RR_EN
        push_exp(1'b0, 32'h0000_3713);
        push_exp(1'b1, 32'h0000_0037);
`else
        push_exp(1'b1, 32'h0000_0037);
        push_exp(1'b0, 32'h0000_3713);
`endif
        cyc = 0; if_n = 0; mem_n = 0; if_cyc = 0; mem_cyc = 0;
        while ((if_n == 0 || mem_n == 0) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_done) begin mem_n++; mem_cyc = cyc; pop_check(1'b1, "tie mem"); mem_req = 1'b0; end
            if (if_done)  begin if_n++;  if_cyc = cyc;  pop_check(1'b0, "tie if");  if_req = 1'b0;  end
        end
        repeat (4) begin
            @(negedge clk);
            if (mem_done) mem_n++;
            if (if_done)  if_n++;
        end
        chk("tie mem pulses", mem_n, 32'd1);
        chk("tie if pulses",  if_n,  32'd1);
`ifdef MEM_CTRL_RR_EN
        chk("tie if cycle",  if_cyc,  32'd6);
        chk("tie mem cycle", mem_cyc, 32'd9);
`else
        chk("tie mem cycle", mem_cyc, 32'd3);
        chk("tie if cycle",  if_cyc,  32'd9);
`endif

        run_read(1'b1, 32'hFFFF_FFFF, 3'd2, 2, 32'h0000_CDAB, 4, "half wrap");
        run_read(1'b1, 32'h0000_1000, 3'd3, 4, 32'h0000_3713, 6, "len3 load");

        // Word store
        w = 32'hDEAD_BEEF;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_3000; mem_len = 3'd4; mem_wdata = w;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                chk("store ram_wr",   {31'd0, ram_wr},   32'd1);
                chk("store ram_a",    ram_a,             32'h0000_3000 + k - 1);
                chk("store ram_dout", {24'd0, ram_dout}, {24'd0, w[8*(k-1) +: 8]});
                chk("store early done", {31'd0, mem_done}, 32'd0);
            end else begin
                chk("store done",     {31'd0, mem_done}, 32'd1);
                chk("store wr off",   {31'd0, ram_wr},   32'd0);
                mem_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("store single pulse", {31'd0, mem_done}, 32'd0);
        chk("store ram word", {ram[16'h3003], ram[16'h3002], ram[16'h3001], ram[16'h3000]}, w);

        // rdy low for 3 cycles after byte 1 of a fetch
        if_req = 1'b1; if_addr = 32'h0000_1004;
        push_exp(1'b0, 32'h4433_2211);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("stall ram_a", ram_a, 32'h0000_1004 + k - 1);
        end
        rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall hold ram_a", ram_a, 32'h0000_1007);
            chk("stall ram_wr",     {31'd0, ram_wr},  32'd0);
            chk("stall if_done",    {31'd0, if_done}, 32'd0);
        end
        rdy = 1'b1;
        cyc = 7;
        while (!if_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("stall done cycle", cyc, 32'd9);
        if (if_done) pop_check(1'b0, "stall fetch");
        if_req = 1'b0;
        @(negedge clk);

        // rst in cycle 2 of a word store
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_3010; mem_len = 3'd4;
        mem_wdata = 32'h1122_3344;
        @(negedge clk);
        chk("abort store started", {31'd0, ram_wr}, 32'd1);
        @(negedge clk);
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort ram_wr",    {31'd0, ram_wr},   32'd0);
        chk("abort ram_a",     ram_a,             32'd0);
        chk("abort ram_dout",  {24'd0, ram_dout}, 32'd0);
        chk("abort mem_done",  {31'd0, mem_done}, 32'd0);
        chk("abort if_data",   if_data,           32'd0);
        chk("abort mem_rdata", mem_rdata,         32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("abort quiet", {30'd0, ram_wr, mem_done}, 32'd0);
        end
        chk("abort partial byte", {24'd0, ram[16'h3011]}, 32'h0000_0033);
        chk("abort untouched",    {24'd0, ram[16'h3012]}, 32'h0000_005A);
        run_read(1'b1, 32'h0000_3010, 3'd2, 2, 32'h0000_3344, 4, "post-rst load");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
